comp_seq: RTL and testbench

//   Iterative magnitude comparator for the MultDiv unit. Walks two operands MSB-first,
//   2 bits per cycle, keeping a running EQ/GT state, using the same cascade rule as
//   the 2-bit comparator stage. Stops early at the first differing digit pair.

---
 rtl/comp_seq.sv | 141 ++++++++++++++
 tb/tb_comp_seq.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/comp_seq.sv
// Iterative two-bit-per-cycle magnitude comparator with a start/done handshake.
// Operands are walked MSB-first and the walk stops at the first differing digit pair.
module comp_seq #(
    parameter int WIDTH  = 32,
    parameter bit SIGNED = 1'b1
) (
    input  logic                                                   clock,
    input  logic                                                   reset_n,
    input  logic                                                   start,
    input  logic [WIDTH-1:0]                                       a,
    input  logic [WIDTH-1:0]                                       b,
    output logic                                                   busy,
    output logic                                                   done,
    output logic                                                   eq,
    output logic                                                   gt,
    output logic                                                   lt,
    output logic [(($clog2(WIDTH/2+1) > 5) ? $clog2(WIDTH/2+1) : 5)-1:0] steps
);

    localparam int DIGITS  = WIDTH / 2;
    localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int STEPS_W = ($clog2(DIGITS + 1) > 5) ? $clog2(DIGITS + 1) : 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [STEPS_W-1:0] steps_q, steps_d;
    logic               eq_q, eq_d;
    logic               gt_q, gt_d;
    logic               lt_q, lt_d;
    logic               eq_run_q, eq_run_d;
    logic               gt_run_q, gt_run_d;

    logic [1:0] dig_a;
    logic [1:0] dig_b;
    logic       first_digit;
    logic       sign_split;
    logic       dig_gt;
    logic       dig_eq;
    logic       eq_nx;
    logic       gt_nx;

    // Operands shift left each step, so the digit under test always sits at the top.
    assign dig_a       = a_q[WIDTH-1 -: 2];
    assign dig_b       = b_q[WIDTH-1 -: 2];
    assign first_digit = (idx_q == IDX_W'(DIGITS - 1));
    assign sign_split  = SIGNED && first_digit && (a_q[WIDTH-1] != b_q[WIDTH-1]);
    assign dig_gt      = sign_split ? ~a_q[WIDTH-1] : (dig_a > dig_b);
    assign dig_eq      = ~sign_split && (dig_a == dig_b);
    assign eq_nx       = eq_run_q & dig_eq;
    assign gt_nx       = gt_run_q | (eq_run_q & dig_gt);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            idx_q    <= '0;
            steps_q  <= '0;
            eq_q     <= 1'b0;
            gt_q     <= 1'b0;
            lt_q     <= 1'b0;
            eq_run_q <= 1'b0;
            gt_run_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            idx_q    <= idx_d;
            steps_q  <= steps_d;
            eq_q     <= eq_d;
            gt_q     <= gt_d;
            lt_q     <= lt_d;
            eq_run_q <= eq_run_d;
            gt_run_q <= gt_run_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        idx_d    = idx_q;
        steps_d  = steps_q;
        eq_d     = eq_q;
        gt_d     = gt_q;
        lt_d     = lt_q;
        eq_run_d = eq_run_q;
        gt_run_d = gt_run_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d      = a;
                    b_d      = b;
                    idx_d    = IDX_W'(DIGITS - 1);
                    steps_d  = '0;
                    eq_d     = 1'b0;
                    gt_d     = 1'b0;
                    lt_d     = 1'b0;
                    eq_run_d = 1'b1;
                    gt_run_d = 1'b0;
                    state_d  = CMP;
                end else begin
                    state_d  = IDLE;
                end
            end
            CMP: begin
                steps_d  = steps_q + STEPS_W'(1);
                a_d      = a_q << 2;
                b_d      = b_q << 2;
                eq_run_d = eq_nx;
                gt_run_d = gt_nx;
                if (!eq_nx || idx_q == '0) begin
                    eq_d    = eq_nx;
                    gt_d    = gt_nx;
                    lt_d    = ~eq_nx & ~gt_nx;
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q - IDX_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy  = (state_q == CMP);
    assign done  = (state_q == DONE);
    assign eq    = eq_q;
    assign gt    = gt_q;
    assign lt    = lt_q;
    assign steps = steps_q;

endmodule

// File: tb/tb_comp_seq.sv
// Randomized bench for comp_seq: a signed and an unsigned instance share stimulus and
// are checked against a plain-arithmetic reference of the compare result and digit count.
module tb_comp_seq;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;

    logic       busy_s, done_s, eq_s, gt_s, lt_s;
    logic [4:0] steps_s;
    logic       busy_u, done_u, eq_u, gt_u, lt_u;
    logic [4:0] steps_u;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    comp_seq #(.WIDTH(32), .SIGNED(1'b1)) u_s (
        .clock(clock), .reset_n(reset_n), .start(start), .a(a), .b(b),
        .busy(busy_s), .done(done_s), .eq(eq_s), .gt(gt_s), .lt(lt_s), .steps(steps_s)
    );

    comp_seq #(.WIDTH(32), .SIGNED(1'b0)) u_u (
        .clock(clock), .reset_n(reset_n), .start(start), .a(a), .b(b),
        .busy(busy_u), .done(done_u), .eq(eq_u), .gt(gt_u), .lt(lt_u), .steps(steps_u)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Result from ordinary integer comparison; step count from the highest differing digit.
    function automatic void model(input logic [31:0] x, input logic [31:0] y, input bit sgn,
                                  output bit e, output bit g, output bit l, output int st);
        e = (x == y);
        if (sgn) g = ($signed(x) > $signed(y));
        else     g = (x > y);
        l  = !e && !g;
        st = 16;
        for (int k = 15; k >= 0; k--) begin
            if (x[2*k +: 2] != y[2*k +: 2]) begin
                st = 16 - k;
                break;
            end
        end
    endfunction

    task automatic launch(input logic [31:0] x, input logic [31:0] y);
        a = x;
        b = y;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        check("busy_after_accept", busy_s, 1);
    endtask

    task automatic finish_cmp(input logic [31:0] x, input logic [31:0] y,
                              input bit inject, input bit linger);
        bit es, gs, ls, eu, gu, lu;
        int sts, stu;
        int cyc;
        model(x, y, 1'b1, es, gs, ls, sts);
        model(x, y, 1'b0, eu, gu, lu, stu);
        cyc = 0;
        while (!done_s && cyc < 40) begin
            if (inject && cyc == 2) begin
                start = 1'b1;
                a = $urandom;
                b = $urandom;
            end
            if (inject && cyc == 3) start = 1'b0;
            @(posedge clock); #1;
            cyc++;
        end
        check("latency", cyc, sts);
        check("done_s", done_s, 1);
        check("busy_at_done", busy_s, 0);
        check("eq_s", eq_s, es);
        check("gt_s", gt_s, gs);
        check("lt_s", lt_s, ls);
        check("steps_s", steps_s, sts);
        check("done_u", done_u, 1);
        check("eq_u", eq_u, eu);
        check("gt_u", gt_u, gu);
        check("lt_u", lt_u, lu);
        check("steps_u", steps_u, stu);
        if (linger) begin
            @(posedge clock); #1;
            check("done_single_pulse", done_s, 0);
            check("idle_not_busy", busy_s, 0);
            check("eq_hold", eq_s, es);
            check("gt_hold", gt_s, gs);
            check("steps_hold", steps_s, sts);
        end
    endtask

    initial begin
        logic [31:0] x, y;
        int mode;

        reset_n = 1'b0;
        start   = 1'b0;
        a       = '0;
        b       = '0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_busy", busy_s, 0);
        check("rst_done", done_s, 0);
        check("rst_eq", eq_s, 0);
        check("rst_gt", gt_s, 0);
        check("rst_lt", lt_s, 0);
        check("rst_steps", steps_s, 0);
        @(negedge clock) reset_n = 1'b1;
        @(posedge clock); #1;

        launch(32'h1234_5678, 32'h1234_5678);
        finish_cmp(32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1);
        launch(32'hFFFF_FFFF, 32'h0000_0001);
        finish_cmp(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
        launch(32'h0000_0003, 32'h0000_0002);
        finish_cmp(32'h0000_0003, 32'h0000_0002, 1'b0, 1'b1);
        launch(32'h4000_0000, 32'h0000_0000);
        finish_cmp(32'h4000_0000, 32'h0000_0000, 1'b0, 1'b1);

        // Start re-pulsed mid-compare must not disturb the running compare.
        x = $urandom;
        launch(x, x ^ 32'h0000_0001);
        finish_cmp(x, x ^ 32'h0000_0001, 1'b1, 1'b1);

        // Asynchronous abort in the middle of an equal-operand compare.
        x = $urandom;
        launch(x, x);
        repeat (4) @(posedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        check("abort_busy", busy_s, 0);
        check("abort_done", done_s, 0);
        check("abort_eq", eq_s, 0);
        check("abort_gt", gt_s, 0);
        check("abort_lt", lt_s, 0);
        check("abort_steps", steps_s, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            check("abort_no_done", done_s, 0);
        end
        @(negedge clock) reset_n = 1'b1;
        @(posedge clock); #1;
        launch(32'h8000_0000, 32'h7FFF_FFFF);
        finish_cmp(32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b1);

        // Start high across DONE chains straight into the next compare.
        x = $urandom;
        y = $urandom;
        launch(32'h0000_0010, 32'h0000_0020);
        finish_cmp(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0);
        a = x;
        b = y;
        start = 1'b1;
        @(posedge clock); #1;
        check("b2b_busy", busy_s, 1);
        check("b2b_done", done_s, 0);
        check("b2b_eq_clr", eq_s, 0);
        check("b2b_gt_clr", gt_s, 0);
        check("b2b_lt_clr", lt_s, 0);
        start = 1'b0;
        finish_cmp(x, y, 1'b0, 1'b1);

        for (int it = 0; it < 150; it++) begin
            mode = $urandom_range(0, 4);
            x = $urandom;
            case (mode)
                0: y = $urandom;
                1: y = x;
                2: y = x ^ (32'h1 << $urandom_range(0, 31));
                3: begin
                    x = {28'h0, 4'($urandom)};
                    y = {28'h0, 4'($urandom)};
                end
                default: y = {~x[31], 31'($urandom)};
            endcase
            launch(x, y);
            finish_cmp(x, y, 1'b0, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
